// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and constants for the UART receive monitor.
// Contents: parity mode encodings, FSM state type, buffered entry payload
// and the parity-check helper. No ports.
package uart_rx_monitor_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Entries are sized for the widest supported character; narrower
    // configurations zero-extend on push and truncate on output.
    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     frame_err;
        logic                     parity_err;
    } rx_entry_t;

    // Odd mode flags an even total of ones; even mode flags an odd total.
    function automatic logic parity_error(
        input logic [MAX_DATA_BITS-1:0] data,
        input logic                     par_bit,
        input logic                     odd
    );
        return (^{data, par_bit}) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_monitor_fifo.sv
// Synchronous FIFO with a registered head entry.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write entry_i (ignored when full unless popping)
//   entry_i      entry to store
//   pop_i        drop the head entry (ignored when empty)
//   head_o       registered head entry
//   valid_o      head_o holds a stored entry
//   full_o       DEPTH entries stored
//   level_o      number of stored entries
module uart_rx_monitor_fifo
    import uart_rx_monitor_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  rx_entry_t                entry_i,
    input  logic                     pop_i,
    output rx_entry_t                head_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    rx_entry_t     mem_q [DEPTH];
    rx_entry_t     head_q;
    rx_entry_t     head_d;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] rptr_d;
    logic [PW-1:0] count_d;
    logic [PW-1:0] level_q;
    logic          valid_q;
    logic          full_q;
    logic          pop_ok_c;
    logic          push_ok_c;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is accepted when paired with a pop.
    assign pop_ok_c  = pop_i & valid_q;
    assign push_ok_c = push_i & (~full_q | pop_ok_c);

    // Next pointers and the entry that becomes head after this cycle.
    always_comb begin
        wptr_d  = wptr_q + PW'(push_ok_c);
        rptr_d  = rptr_q + PW'(pop_ok_c);
        count_d = wptr_d - rptr_d;
        head_d  = head_q;
        if (count_d == '0) begin
            head_d = head_q;
        end else if (push_ok_c && (rptr_d == wptr_q)) begin
            head_d = entry_i;
        end else begin
            head_d = mem_q[rptr_d[AW-1:0]];
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wptr_q[AW-1:0]] <= entry_i;
        end
    end

    // Pointers and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            head_q  <= head_d;
            valid_q <= (count_d != '0);
            full_q  <= (count_d == PW'(DEPTH));
            level_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: recovers characters from an asynchronous serial
// line with framing/parity status and hands them off over valid/ready.
// Build option: define UART_RX_MONITOR_FIFO_EN for a FIFO_DEPTH-entry
// FIFO; otherwise a single holding register buffers one character.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_i            serial line, idle high, asynchronous to clk
//   data_o          head character, LSB = first bit received
//   frame_err_o     head character had a low stop bit
//   parity_err_o    head character failed the parity check
//   valid_o         head entry present
//   ready_i         consumer accepts the head entry
//   overrun_o       sticky: a character was dropped
//   clr_i           clears overrun_o
//   busy_o          a frame is in progress
//   level_o         number of stored entries
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overrun_o,
    input  logic                          clr_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam bit            PAR_EN    = (PARITY != PAR_NONE);
    localparam logic          PAR_ODD_M = (PARITY == PAR_ODD);

    logic                 rx_meta_q;
    logic                 rxs_q;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 frame_err_q;
    logic                 par_err_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic                 tick_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 full_c;
    logic                 overrun_set_c;
    rx_entry_t            entry_c;
    rx_entry_t            head;
    logic                 head_valid;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    assign tick_c = (cnt_q == '0);

    // Push happens on the final stop sample; the stop bit being sampled
    // right now is folded into the frame error directly.
    assign push_c = (state_q == ST_STOP) && tick_c && (stop_idx_q == LAST_STOP);

    always_comb begin
        entry_c            = '0;
        entry_c.data       = MAX_DATA_BITS'(shreg_q);
        entry_c.frame_err  = frame_err_q | ~rxs_q;
        entry_c.parity_err = par_err_q;
    end

    // Receive FSM with registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_idx_q  <= 1'b0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_q     <= ST_START;
                        cnt_q       <= HALF_LOAD;
                        frame_err_q <= 1'b0;
                        par_err_q   <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_c) begin
                        if (rxs_q) begin
                            // Line recovered before mid start bit: glitch.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                            cnt_q   <= FULL_LOAD;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_c) begin
                        shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_LOAD;
                        if (idx_q == LAST_IDX) begin
                            state_q    <= PAR_EN ? ST_PAR : ST_STOP;
                            stop_idx_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_PAR: begin
                    if (tick_c) begin
                        par_err_q  <= parity_error(MAX_DATA_BITS'(shreg_q), rxs_q, PAR_ODD_M);
                        cnt_q      <= FULL_LOAD;
                        state_q    <= ST_STOP;
                        stop_idx_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_c) begin
                        if (!rxs_q) begin
                            frame_err_q <= 1'b1;
                        end
                        if (stop_idx_q == LAST_STOP) begin
                            // A low final stop means a break: hold off until the line idles.
                            state_q <= rxs_q ? ST_IDLE : ST_BRK;
                            busy_q  <= ~rxs_q;
                        end else begin
                            stop_idx_q <= 1'b1;
                            cnt_q      <= FULL_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_BRK: begin
                    if (rxs_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_MONITOR_FIFO_EN
    logic [LW-1:0] fifo_level;

    uart_rx_monitor_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .entry_i (entry_c),
        .pop_i   (pop_c),
        .head_o  (head),
        .valid_o (head_valid),
        .full_o  (full_c),
        .level_o (fifo_level)
    );

    assign level_o = fifo_level;
`else
    rx_entry_t hold_q;
    logic      hold_valid_q;

    // Single holding register; a same-cycle pop makes room for a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (push_c && (!hold_valid_q || pop_c)) begin
            hold_q       <= entry_c;
            hold_valid_q <= 1'b1;
        end else if (pop_c) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign head       = hold_q;
    assign head_valid = hold_valid_q;
    assign full_c     = hold_valid_q;
    assign level_o    = LW'(hold_valid_q);
`endif

    assign pop_c         = head_valid & ready_i;
    assign overrun_set_c = push_c & full_c & ~pop_c;

    // Sticky overrun; a drop in the same cycle as clr_i wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (overrun_set_c) begin
            overrun_q <= 1'b1;
        end else if (clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    // Entry bits above DATA_BITS are always zero and never leave the block.
    logic unused_head_bits;
    assign unused_head_bits = ^head.data;

    assign data_o       = head.data[DATA_BITS-1:0];
    assign frame_err_o  = head.frame_err;
    assign parity_err_o = head.parity_err;
    assign valid_o      = head_valid;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor (16 clocks/bit, 8E1, depth 4).
module tb_uart_rx_monitor;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DB    = 8;
    localparam int unsigned PAR   = 2;
    localparam int unsigned STOPS = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_MONITOR_FIFO_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif
    // Last stop sample in bit periods after the start bit, plus sync/detect delay.
    localparam int unsigned RISE_LAT = 3 + CPB / 2 + (DB + 1 + STOPS) * CPB;

    typedef struct {
        logic [DB-1:0] data;
        logic          fe;
        logic          pe;
    } ent_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rx_i    = 1'b1;
    logic          ready_i = 1'b0;
    logic          clr_i   = 1'b0;
    logic [DB-1:0] data_o;
    logic          frame_err_o;
    logic          parity_err_o;
    logic          valid_o;
    logic          overrun_o;
    logic          busy_o;
    logic [LW-1:0] level_o;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;
    int unsigned cyc          = 0;
    int unsigned rise_cyc     = 0;
    int unsigned start_cyc    = 0;
    logic        prev_valid   = 1'b0;
    ent_t        obs_q[$];

    uart_rx_monitor #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .PARITY       (PAR),
        .STOP_BITS    (STOPS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .clr_i        (clr_i),
        .busy_o       (busy_o),
        .level_o      (level_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted entry and the edge at which valid_o last rose.
    always @(negedge clk) begin
        if (valid_o && ready_i) obs_q.push_back('{data_o, frame_err_o, parity_err_o});
        if (valid_o && !prev_valid) rise_cyc <= cyc;
        prev_valid <= valid_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        ticks(CPB);
    endtask

    // Correct even-parity bit: makes the total count of ones even.
    function automatic logic even_bit(input logic [DB-1:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop_val);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
        drive_bit(pbit);
        for (int s = 0; s < int'(STOPS); s++) drive_bit(stop_val);
        rx_i = 1'b1;
    endtask

    task automatic wait_obs(input int unsigned n, input int unsigned budget);
        int unsigned left = budget;
        while (obs_q.size() < n && left > 0) begin
            tick();
            left--;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0; clr_i = 1'b0;
        ticks(3);
        tests_run++;
        if ({valid_o, frame_err_o, parity_err_o, overrun_o, busy_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000", {valid_o, frame_err_o, parity_err_o, overrun_o, busy_o});
        end
        tests_run++;
        if (data_o !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data_o); end
        tests_run++;
        if (level_o !== '0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level_o); end
        rst_n = 1'b1;
        ticks(4);
        tests_run++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: valid %b busy %b want 0 0", valid_o, busy_o);
        end
    endtask

    task automatic test_basic();
        int unsigned exp_rise;
        ready_i = 1'b0;
        obs_q.delete();
        send_frame(8'h55, even_bit(8'h55), 1'b1);
        exp_rise = start_cyc + RISE_LAT;
        ticks(CPB);
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 8'h55 || frame_err_o !== 1'b0 || parity_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_entry: valid %b data %h fe %b pe %b want 1 55 0 0", valid_o, data_o, frame_err_o, parity_err_o);
        end
        tests_run++;
        if (level_o !== LW'(1) || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_level_busy: level %0d busy %b want 1 0", level_o, busy_o);
        end
        // One cycle of slack for where the synchronizer delay is counted.
        tests_run++;
        if (rise_cyc + 1 < exp_rise || rise_cyc > exp_rise + 1) begin
            tests_failed++;
            $display("FAIL basic_valid_timing: rose at edge %0d want %0d+-1", rise_cyc, exp_rise);
        end
        ready_i = 1'b1;
        ticks(2);
        tests_run++;
        if (obs_q.size() != 1 || valid_o !== 1'b0 || level_o !== '0) begin
            tests_failed++;
            $display("FAIL basic_pop: popped %0d valid %b level %0d want 1 0 0", obs_q.size(), valid_o, level_o);
        end
    endtask

    task automatic test_parity();
        ent_t exp_q[$];
        ready_i = 1'b1;
        obs_q.delete();
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b0, 1'b1);
        exp_q.push_back('{8'hA3, 1'b0, 1'b1});
        exp_q.push_back('{8'hA3, 1'b0, 1'b0});
        // Randomized frames: bad parity and low stop bits mixed in.
        for (int n = 0; n < 10; n++) begin
            logic [DB-1:0] d;
            logic          bad_par;
            logic          stop_lo;
            d       = DB'($urandom);
            bad_par = ($urandom_range(0, 2) == 0);
            stop_lo = ($urandom_range(0, 3) == 0);
            send_frame(d, even_bit(d) ^ bad_par, ~stop_lo);
            exp_q.push_back('{d, stop_lo, bad_par});
            if (stop_lo) ticks(CPB);
            ticks($urandom_range(0, 3));
        end
        ticks(CPB);
        wait_obs(exp_q.size(), 4 * CPB);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL parity_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].fe !== exp_q[i].fe || obs_q[i].pe !== exp_q[i].pe) begin
                tests_failed++;
                $display("FAIL parity_entry[%0d]: got %h fe %b pe %b want %h fe %b pe %b", i,
                         obs_q[i].data, obs_q[i].fe, obs_q[i].pe, exp_q[i].data, exp_q[i].fe, exp_q[i].pe);
            end
        end
    endtask

    task automatic test_break();
        logic busy_dropped = 1'b0;
        ready_i = 1'b1;
        obs_q.delete();
        send_frame(8'h96, even_bit(8'h96), 1'b0);
        rx_i = 1'b0;
        for (int i = 0; i < int'(40 * CPB); i++) begin
            tick();
            if (busy_o !== 1'b1) busy_dropped = 1'b1;
        end
        tests_run++;
        if (busy_dropped) begin tests_failed++; $display("FAIL break_busy: busy_o dropped while line low, want held 1"); end
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL break_count: got %0d entries want 1", obs_q.size());
        end else if (obs_q[0].data !== 8'h96 || obs_q[0].fe !== 1'b1 || obs_q[0].pe !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_entry: got %h fe %b pe %b want 96 fe 1 pe 0", obs_q[0].data, obs_q[0].fe, obs_q[0].pe);
        end
        rx_i = 1'b1;
        ticks(4);
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL break_release: busy %b want 0", busy_o); end
        send_frame(8'h3A, even_bit(8'h3A), 1'b1);
        wait_obs(2, 4 * CPB);
        tests_run++;
        if (obs_q.size() != 2 || obs_q[obs_q.size()-1].data !== 8'h3A || obs_q[obs_q.size()-1].fe !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_next_frame: count %0d last %h want 2 3A", obs_q.size(), obs_q[obs_q.size()-1].data);
        end
    endtask

    task automatic test_glitch();
        logic saw_busy = 1'b0;
        ready_i = 1'b1;
        obs_q.delete();
        rx_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy_o === 1'b1) saw_busy = 1'b1;
        end
        rx_i = 1'b1;
        for (int i = 0; i < int'(CPB); i++) begin
            tick();
            if (busy_o === 1'b1) saw_busy = 1'b1;
        end
        tests_run++;
        if (!saw_busy || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: saw %b final %b want 1 0", saw_busy, busy_o);
        end
        ticks(2 * CPB);
        tests_run++;
        if (obs_q.size() != 0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_no_entry: entries %0d valid %b want 0 0", obs_q.size(), valid_o);
        end
    endtask

    task automatic test_overrun();
        int unsigned kept;
        kept = (CAP < 5) ? CAP : 5;
        ready_i = 1'b0;
        obs_q.delete();
        for (int d = 1; d <= 5; d++) send_frame(DB'(d), even_bit(DB'(d)), 1'b1);
        ticks(CPB);
        tests_run++;
        if (level_o !== LW'(kept) || overrun_o !== (CAP < 5)) begin
            tests_failed++;
            $display("FAIL overrun_state: level %0d overrun %b want %0d %b", level_o, overrun_o, kept, CAP < 5);
        end
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 8'h01) begin
            tests_failed++;
            $display("FAIL overrun_head: valid %b data %h want 1 01", valid_o, data_o);
        end
        ready_i = 1'b1;
        ticks(CAP + 3);
        ready_i = 1'b0;
        tests_run++;
        if (obs_q.size() != kept) begin
            tests_failed++;
            $display("FAIL overrun_pops: got %0d entries want %0d", obs_q.size(), kept);
        end
        for (int i = 0; i < obs_q.size() && i < int'(kept); i++) begin
            tests_run++;
            if (obs_q[i].data !== DB'(i + 1)) begin
                tests_failed++;
                $display("FAIL overrun_order[%0d]: got %h want %h", i, obs_q[i].data, DB'(i + 1));
            end
        end
        tests_run++;
        if (overrun_o !== 1'b1 || level_o !== '0) begin
            tests_failed++;
            $display("FAIL overrun_sticky: overrun %b level %0d want 1 0", overrun_o, level_o);
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tests_run++;
        if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b want 0", overrun_o); end
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d = 8'h3C;
        ready_i = 1'b0;
        send_frame(8'h11, even_bit(8'h11), 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx_i = d[3];
        ticks(CPB / 2);
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({valid_o, busy_o, overrun_o, frame_err_o, parity_err_o} !== 5'b0 || data_o !== '0 || level_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: valid %b busy %b data %h level %0d want 0 0 00 0", valid_o, busy_o, data_o, level_o);
        end
        rx_i = 1'b1;
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        obs_q.delete();
        ready_i = 1'b1;
        send_frame(d, even_bit(d), 1'b1);
        wait_obs(1, 4 * CPB);
        tests_run++;
        if (obs_q.size() != 1 || obs_q[0].data !== 8'h3C || obs_q[0].fe !== 1'b0 || obs_q[0].pe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: count %0d data %h want 1 3C", obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Synthesizable, parametrised UART receive monitor for the SoC and its benches. It observes a serial line, such as the `uart0` TX pad, and recovers each character with framing and parity status. Characters are buffered and handed off through a valid/ready port. It supersedes fixed-baud, 8N1-only, print-only decoding, so the same block can be used in simulation and on the DE10-Lite fabric.

## Interface
- `CLKS_PER_BIT`, default 434 — clock cycles per bit; 434 gives 115200 baud at 50 MHz; minimum 8.
- `DATA_BITS`, default 8 — data bits per character; range 5..9.
- `PARITY`, default 0 — 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1 — 1 or 2.
- `FIFO_DEPTH`, default 16 — entries; power of two, ≥ 2; used only with `UART_RX_MONITOR_FIFO_EN`.
- `clk` in 1 — the only clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `rx_i` in 1 — serial line; asynchronous to `clk`; idle level is high.
- `data_o` out `DATA_BITS` — head character, LSB = first bit received.
- `frame_err_o` out 1 — head character had a low stop bit.
- `parity_err_o` out 1 — head character failed the parity check; always 0 when `PARITY` = 0.
- `valid_o` out 1 — the head entry is present.
- `ready_i` in 1 — consumer accepts the head entry; a pop occurs when `valid_o & ready_i`.
- `overrun_o` out 1 — sticky; a character was dropped.
- `clr_i` in 1 — clears `overrun_o`.
- `busy_o` out 1 — a frame is in progress (FSM is not in IDLE).
- `level_o` out `$clog2(FIFO_DEPTH)+1` — number of stored entries.

## Operation
- **Input synchronizer:** `rx_i` passes through a 2-flop synchronizer whose flops reset to 1. All logic below uses the synchronized value `rxs`.
- **Bit counter:** a down-counter `$clog2(CLKS_PER_BIT)` bits wide and a bit index `$clog2(DATA_BITS)` bits wide.
- **FSM states:** IDLE, START, DATA, PAR, STOP, BRK.
- **IDLE → START:** taken when `rxs` = 0. The counter loads `CLKS_PER_BIT/2 - 1`.
- **START:** when the counter reaches 0, sample `rxs`.
  - `rxs` = 1: glitch; return to IDLE with nothing pushed.
  - `rxs` = 0: go to DATA; the counter loads `CLKS_PER_BIT - 1`.
- **DATA:** sample at each counter expiry and shift in LSB-first. After `DATA_BITS` samples, go to PAR if `PARITY` ≠ 0, otherwise go to STOP.
- **PAR:** sample the parity bit and compute the error flag.
  - Odd parity: error when the XOR of data and parity bit is 0.
  - Even parity: error when that XOR is 1.
- **STOP:** sample `STOP_BITS` stop bits. `frame_err` is set if any stop sample is 0.
  - On the final stop sample, push {`data`, `frame_err`, `parity_err`}.
  - Next state is IDLE if `rxs` = 1, or BRK if `rxs` = 0.
- **BRK:** wait for `rxs` = 1, then go to IDLE. A held-low line therefore yields exactly one entry.
- **Push into a full buffer:** the entry is dropped and `overrun_o` is set.
  - Exception: if a pop happens in the same cycle, the push is accepted and no overrun occurs.
- **Overrun set/clear collision:** set has priority over `clr_i` in the same cycle.
- **Reset values:** all outputs are 0; FSM is IDLE; buffer is empty. Reset asserted mid-frame abandons the frame.

## Timing
- **Start detect:** 2 cycles of synchronizer delay from an `rx_i` edge to `rxs`.
- **Sample point:** bit *n* is sampled `CLKS_PER_BIT/2 + n*CLKS_PER_BIT` cycles after the start edge is seen on `rxs` (start bit is *n* = 0).
- **Push to valid:** `valid_o`, `data_o` and the flags are registered and update in the cycle after the push.
- **Pop:** the next head entry, or `valid_o` = 0, appears in the cycle after the pop.
- **Stability:** `data_o` and the flags are stable while `valid_o` = 1 and `ready_i` = 0.
- **`level_o`:** updates in the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.

## Configuration
- **`UART_RX_MONITOR_FIFO_EN` defined:**
  - Entries are buffered in a `FIFO_DEPTH`-entry FIFO.
  - Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally.
- **`UART_RX_MONITOR_FIFO_EN` undefined:**
  - A single holding register replaces the FIFO.
  - `level_o` ∈ {0, 1}.
  - A push while the register is full and not popped in that cycle sets overrun.
  - `FIFO_DEPTH` is ignored.

## Structure
- **Package `uart_rx_monitor_pkg`:**
  - Parity encoding constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
  - FSM state typedef.
  - Entry struct typedef: data and two flags.
- **Sub-module `uart_rx_monitor_fifo`:**
  - Synchronous FIFO with a registered head.
  - Provides push, pop, full, empty and level.
  - Instantiated only under the macro.

## Test plan
- **Basic 8N1 receive:** `CLKS_PER_BIT`=16, 8N1; send 0x55 → one entry: `data_o`=0x55, both error flags 0, `valid_o` rises 1 cycle after the stop-bit sample.
- **Parity error:** `PARITY`=2; send 0xA3 with parity bit 1 (correct even parity is 0) → `data_o`=0xA3, `parity_err_o`=1; the same frame with parity bit 0 → `parity_err_o`=0.
- **Break / low stop bit:** drive the stop bit low and hold the line low for 40 bit-times → exactly one entry with `frame_err_o`=1; `busy_o` stays 1 until `rx_i` goes high; the next frame is received correctly.
- **Glitch rejection:** `rx_i` low for 4 cycles (`CLKS_PER_BIT`=16) → no entry; `busy_o` returns to 0.
- **Overrun:** macro on, `FIFO_DEPTH`=4, `ready_i`=0; send 0x01..0x05 → `level_o`=4 and `overrun_o`=1; pops return 0x01..0x04 in order; pulsing `clr_i` clears `overrun_o`.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 → all outputs 0; after release, 0x3C is received intact.
